// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Widths, encodings and pipeline bundle types.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port.
// master = fetch side, slave = memory side.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            IMEM_REQ_V;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_REQ_RDY;
  logic            IMEM_RESP_V;
  logic [ILEN-1:0] IMEM_RESP_DATA;

  modport master (
    output IMEM_REQ_V,
    output IMEM_ADDR,
    input  IMEM_REQ_RDY,
    input  IMEM_RESP_V,
    input  IMEM_RESP_DATA
  );

  modport slave (
    input  IMEM_REQ_V,
    input  IMEM_ADDR,
    output IMEM_REQ_RDY,
    output IMEM_RESP_V,
    output IMEM_RESP_DATA
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous power-of-two FIFO with flush.
// Used for both the instruction queue and the in-flight PC FIFO.
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge CLK) begin
    if (do_push && !flush && !RESET) mem[wp] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, imem requests, instruction queue, DE register.
// Optional misaligned-redirect trap: FETCH_MISALIGN_CHK_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int              QDEPTH   = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  fetch_stage_if.master   imem,
  input  logic            BR_TAKEN,
  input  logic [XLEN-1:0] BR_TARGET,
  input  logic            DE_STALL,
  output logic [XLEN-1:0] DE_NPC,
  output logic [ILEN-1:0] DE_IR,
  output logic            DE_V
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            FETCH_ERR
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = CW + 3;
  localparam int EW = $bits(fetch_ent_t);
  localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tgt;
  logic [DW-1:0]   drop_q;
  logic            halt;

  logic            req_v;
  logic            accept;
  logic            resp_ok;
  logic            de_free;
  logic            wt;
  logic [CW:0]     credit;

  logic            iq_push;
  logic            iq_pop;
  logic            iq_full;
  logic            iq_empty;
  logic [CW-1:0]   iq_cnt;
  fetch_ent_t      iq_wdata;
  fetch_ent_t      iq_rdata;

  logic            fq_full;
  logic            fq_empty;
  logic [CW-1:0]   fq_cnt;
  logic [XLEN-1:0] fq_rdata;

  // Fetch addresses are word aligned; low target bits are discarded.
  assign tgt = BR_TARGET & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;
  logic mis;

  assign mis       = BR_TAKEN && (BR_TARGET[1:0] != 2'b00);
  assign halt      = err_q;
  assign FETCH_ERR = err_q;

  // Sticky trap on a misaligned redirect target.
  always_ff @(posedge CLK) begin
    if (RESET)    err_q <= 1'b0;
    else if (mis) err_q <= 1'b1;
  end
`else
  assign halt = 1'b0;
`endif

  assign credit  = {1'b0, fq_cnt} + {1'b0, iq_cnt};
  assign req_v   = !RESET && !BR_TAKEN && !halt
                && !fq_full && (credit < QLIM);
  assign accept  = req_v && imem.IMEM_REQ_RDY;

  assign imem.IMEM_REQ_V = req_v;
  assign imem.IMEM_ADDR  = pc_q;

  assign resp_ok = imem.IMEM_RESP_V && (drop_q == '0)
                && !fq_empty && !BR_TAKEN;
  assign de_free = !DE_V || !DE_STALL;
  assign wt      = resp_ok && iq_empty && de_free;
  assign iq_pop  = de_free && !iq_empty && !BR_TAKEN;
  assign iq_push = resp_ok && !wt && (!iq_full || iq_pop);

  assign iq_wdata.pc = fq_rdata;
  assign iq_wdata.ir = imem.IMEM_RESP_DATA;

  fetch_queue #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_iq (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (iq_push),
    .wdata (iq_wdata),
    .pop   (iq_pop),
    .rdata (iq_rdata),
    .flush (BR_TAKEN),
    .count (iq_cnt),
    .full  (iq_full),
    .empty (iq_empty)
  );

  fetch_queue #(
    .W     (XLEN),
    .DEPTH (QDEPTH)
  ) u_fq (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (accept),
    .wdata (pc_q),
    .pop   (resp_ok),
    .rdata (fq_rdata),
    .flush (BR_TAKEN),
    .count (fq_cnt),
    .full  (fq_full),
    .empty (fq_empty)
  );

  // PC: redirect wins, otherwise step on each accepted request.
  always_ff @(posedge CLK) begin
    if (RESET)         pc_q <= RESET_PC;
    else if (BR_TAKEN) pc_q <= tgt;
    else if (accept)   pc_q <= pc_q + XLEN'(INST_BYTES);
  end

  // Wrong-path responses still owed by memory after a redirect.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      drop_q <= '0;
    end else if (BR_TAKEN) begin
      if (imem.IMEM_RESP_V && ((drop_q + DW'(fq_cnt)) != '0))
        drop_q <= drop_q + DW'(fq_cnt) - DW'(1);
      else
        drop_q <= drop_q + DW'(fq_cnt);
    end else if (imem.IMEM_RESP_V && (drop_q != '0)) begin
      drop_q <= drop_q - DW'(1);
    end
  end

  // Decode register: flush on redirect, hold on stall, else refill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DE_V   <= 1'b0;
      DE_NPC <= '0;
      DE_IR  <= '0;
    end else if (BR_TAKEN || halt) begin
      DE_V   <= 1'b0;
    end else if (de_free) begin
      if (!iq_empty) begin
        DE_V   <= 1'b1;
        DE_NPC <= iq_rdata.pc;
        DE_IR  <= iq_rdata.ir;
      end else if (wt) begin
        DE_V   <= 1'b1;
        DE_NPC <= fq_rdata;
        DE_IR  <= imem.IMEM_RESP_DATA;
      end else begin
        DE_V   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Memory model with variable latency plus an in-order scoreboard.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [63:0] RPC = 64'h1000;
  localparam int          QD  = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BR_TAKEN;
  logic [63:0] BR_TARGET;
  logic        DE_STALL;
  logic [63:0] DE_NPC;
  logic [31:0] DE_IR;
  logic        DE_V;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        FETCH_ERR;
`endif

  fetch_stage_if imem();

  fetch_stage #(
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .imem      (imem),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .DE_STALL  (DE_STALL),
    .DE_NPC    (DE_NPC),
    .DE_IR     (DE_IR),
    .DE_V      (DE_V)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .FETCH_ERR (FETCH_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_de   = 0;
  int cyc    = 0;
  int lat    = 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_0013;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [63:0] a;
    int          due;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ir;
  } exp_t;

  mreq_t mq[$];
  exp_t  sb[$];
  logic [63:0] exp_pc;

  // Memory: in-order responses, lat cycles after acceptance.
  always @(posedge CLK) begin
    if (RESET) begin
      mq.delete();
    end else begin
      if (imem.IMEM_RESP_V === 1'b1) void'(mq.pop_front());
      if (imem.IMEM_REQ_V && imem.IMEM_REQ_RDY)
        mq.push_back('{imem.IMEM_ADDR, cyc + lat});
    end
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem.IMEM_RESP_V    = 1'b1;
      imem.IMEM_RESP_DATA = mdata(mq[0].a);
    end else begin
      imem.IMEM_RESP_V    = 1'b0;
      imem.IMEM_RESP_DATA = '0;
    end
  end

  // Scoreboard: push on accepted request, compare on decode.
  always @(negedge CLK) begin
    if (RESET) begin
      sb.delete();
      exp_pc = RPC;
    end else if (BR_TAKEN) begin
      sb.delete();
      exp_pc = BR_TARGET & ~64'd3;
    end else begin
      if (imem.IMEM_REQ_V && imem.IMEM_REQ_RDY) begin
        chk("imem_addr", imem.IMEM_ADDR, exp_pc);
        sb.push_back('{exp_pc, mdata(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        n_acc++;
      end
      if (DE_V) begin
        if (sb.size() == 0) begin
          chk("de_v_no_expect", {63'd0, DE_V}, 64'd0);
        end else begin
          chk("de_npc", DE_NPC, sb[0].pc);
          chk("de_ir", {32'd0, DE_IR}, {32'd0, sb[0].ir});
          if (!DE_STALL) begin
            void'(sb.pop_front());
            n_de++;
          end
        end
      end
    end
  end

  task automatic wait_de(input string tag);
    int k;
    k = 0;
    while (!DE_V && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, {63'd0, DE_V}, 64'd1);
  endtask

  task automatic redirect(input logic [63:0] t);
    BR_TAKEN  = 1'b1;
    BR_TARGET = t;
    tick();
    BR_TAKEN  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;
    logic [63:0] rt;
    RESET     = 1'b1;
    BR_TAKEN  = 1'b0;
    BR_TARGET = '0;
    DE_STALL  = 1'b0;
    imem.IMEM_REQ_RDY = 1'b1;
    repeat (3) tick();

    @(negedge CLK);
    chk("rst_req_v", {63'd0, imem.IMEM_REQ_V}, 64'd0);
    chk("rst_addr", imem.IMEM_ADDR, RPC);
    chk("rst_de_v", {63'd0, DE_V}, 64'd0);
    chk("rst_de_ir", {32'd0, DE_IR}, 64'd0);
    chk("rst_de_npc", DE_NPC, 64'd0);

    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("first_req_v", {63'd0, imem.IMEM_REQ_V}, 64'd1);
    chk("first_addr", imem.IMEM_ADDR, RPC);
    chk("first_de_v0", {63'd0, DE_V}, 64'd0);
    @(negedge CLK);
    chk("first_de_v1", {63'd0, DE_V}, 64'd0);
    @(negedge CLK);
    chk("first_de_v2", {63'd0, DE_V}, 64'd1);
    chk("first_npc", DE_NPC, RPC);

    repeat (3) tick();
    d0 = n_de;
    repeat (20) tick();
    chk("throughput", 64'(n_de - d0), 64'd20);

    DE_STALL = 1'b1;
    a0 = n_acc;
    repeat (6) tick();
    chk("stall_acc_le_q", {63'd0, (n_acc - a0) <= QD}, 64'd1);
    @(negedge CLK);
    chk("stall_full", {63'd0, imem.IMEM_REQ_V}, 64'd0);
    chk("stall_hold_v", {63'd0, DE_V}, 64'd1);
    tick();
    DE_STALL = 1'b0;
    repeat (12) tick();

    lat = 3;
    repeat (10) tick();
    redirect(64'h2000);
    @(negedge CLK);
    chk("br3_de_v", {63'd0, DE_V}, 64'd0);
    chk("br3_req_v", {63'd0, imem.IMEM_REQ_V}, 64'd1);
    chk("br3_addr", imem.IMEM_ADDR, 64'h2000);
    wait_de("br3_wait");
    chk("br3_npc", DE_NPC, 64'h2000);

    lat = 1;
    repeat (6) tick();
    DE_STALL = 1'b1;
    repeat (4) tick();
    @(negedge CLK);
    chk("brst_pre_v", {63'd0, DE_V}, 64'd1);
    tick();
    redirect(64'h3000);
    @(negedge CLK);
    chk("brst_de_v", {63'd0, DE_V}, 64'd0);
    chk("brst_req_v", {63'd0, imem.IMEM_REQ_V}, 64'd1);
    chk("brst_addr", imem.IMEM_ADDR, 64'h3000);
    tick();
    DE_STALL = 1'b0;
    repeat (6) tick();

    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge CLK);
    chk("wrap_top", imem.IMEM_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge CLK);
    chk("wrap_zero", imem.IMEM_ADDR, 64'd0);
    wait_de("wrap_wait");
    chk("wrap_npc", DE_NPC, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (6) tick();

    lat = 2;
    for (int i = 0; i < 300; i++) begin
      DE_STALL          = ($urandom_range(0, 9) < 3);
      imem.IMEM_REQ_RDY = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) begin
        rt = {32'd0, $urandom} & ~64'd3;
        BR_TAKEN  = 1'b1;
        BR_TARGET = rt;
      end else begin
        BR_TAKEN = 1'b0;
      end
      tick();
    end
    BR_TAKEN          = 1'b0;
    DE_STALL          = 1'b0;
    imem.IMEM_REQ_RDY = 1'b1;
    repeat (20) tick();

    RESET = 1'b1;
    repeat (2) tick();
    @(negedge CLK);
    chk("mrst_de_v", {63'd0, DE_V}, 64'd0);
    chk("mrst_req_v", {63'd0, imem.IMEM_REQ_V}, 64'd0);
    chk("mrst_addr", imem.IMEM_ADDR, RPC);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("mrst_req1", {63'd0, imem.IMEM_REQ_V}, 64'd1);
    wait_de("mrst_wait");
    chk("mrst_npc", DE_NPC, RPC);
    repeat (4) tick();

    redirect(64'h2002);
    @(negedge CLK);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_err", {63'd0, FETCH_ERR}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("mis_req_v", {63'd0, imem.IMEM_REQ_V}, 64'd0);
      chk("mis_de_v", {63'd0, DE_V}, 64'd0);
      @(negedge CLK);
    end
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("mis_clr", {63'd0, FETCH_ERR}, 64'd0);
`else
    chk("mis_addr", imem.IMEM_ADDR, 64'h2000);
    wait_de("mis_wait");
    chk("mis_npc", DE_NPC, 64'h2000);
`endif
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
